// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master shift engine: FSM states, latched
// mode-bit positions and the edge-counter width helper.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MODE_CPOL = 1;
    localparam int unsigned MODE_CPHA = 0;

    // Wide enough to hold 2*data_width, the final edge number.
    function automatic int unsigned edge_cnt_width(input int unsigned data_width);
        return $clog2(2 * data_width) + 1;
    endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Turns the BRG square wave into one-clk half-period ticks; the history
// register is held at 0 while the BRG is being cleared.
module spi_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic baud,
    output logic tick
);

    logic baud_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_q <= 1'b0;
        end else if (clr) begin
            baud_q <= 1'b0;
        end else begin
            baud_q <= baud;
        end
    end

    assign tick = en & (baud ^ baud_q);

endmodule

// File: rtl/spi_master_shifter.sv
// SPI master shift engine: one full-duplex DataWidth-bit transfer per start,
// paced by half-period ticks derived from the BRG baud clock.
module spi_master_shifter
    import spi_pkg::*;
#(
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DataWidth-1:0] tx_data,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 lsb_first,
    input  logic                 baud,
    input  logic                 miso,
    output logic                 brg_clr,
    output logic                 sck,
    output logic                 mosi,
    output logic                 ss_n,
    output logic                 busy,
    output logic                 done,
    output logic [DataWidth-1:0] rx_data
);

    localparam int unsigned          EdgeW    = edge_cnt_width(DataWidth);
    localparam logic [EdgeW-1:0]     LastEdge = EdgeW'(2 * DataWidth);

    state_t               state;
    state_t               state_next;
    logic [EdgeW-1:0]     edge_cnt;
    logic [EdgeW-1:0]     edge_next;
    logic [DataWidth-1:0] tx_sr;
    logic [DataWidth-1:0] tx_shifted;
    logic [DataWidth-1:0] rx_sr;
    logic [DataWidth-1:0] rx_shifted;
    logic [1:0]           mode;
    logic                 lsb_q;
    logic                 in_xfer;
    logic                 tick;
    logic                 leading;
    logic                 last_edge;
    logic                 do_sample;
    logic                 do_drive;
    logic                 tx_bit;

    function automatic logic first_bit(input logic [DataWidth-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DataWidth-1];
    endfunction

    function automatic logic [DataWidth-1:0] shift_out(input logic [DataWidth-1:0] w,
                                                       input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DataWidth-1:0] shift_in(input logic [DataWidth-1:0] w,
                                                      input logic b, input logic lsb);
        return lsb ? {b, w[DataWidth-1:1]} : {w[DataWidth-2:0], b};
    endfunction

    assign in_xfer = (state == XFER);

    // BRG is released already in the accepting cycle, so the first SCK edge
    // lands 2^SPR clk after acceptance and back-to-back gaps clear only once.
    assign brg_clr = !in_xfer && !((state == IDLE) && start);

    spi_edge_detect u_edge_detect (
        .clk  (clk),
        .rst  (rst),
        .clr  (brg_clr),
        .en   (in_xfer),
        .baud (baud),
        .tick (tick)
    );

    always_comb begin
        edge_next  = edge_cnt + 1'b1;
        leading    = edge_next[0];
        last_edge  = (edge_next == LastEdge);
        do_sample  = tick && (leading ^ mode[MODE_CPHA]);
        do_drive   = tick && (leading ? mode[MODE_CPHA]
                                      : (!mode[MODE_CPHA] && !last_edge));
        tx_bit     = first_bit(tx_sr, lsb_q);
        tx_shifted = shift_out(tx_sr, lsb_q);
        rx_shifted = do_sample ? shift_in(rx_sr, miso, lsb_q) : rx_sr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = XFER;
            XFER:    if (tick && last_edge) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rx_data/done are loaded on the final edge so both are valid together
    // for the single DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck      <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            mode     <= '0;
            lsb_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sck  <= cpol;
                    ss_n <= 1'b1;
                    if (start) begin
                        mode[MODE_CPOL] <= cpol;
                        mode[MODE_CPHA] <= cpha;
                        lsb_q    <= lsb_first;
                        ss_n     <= 1'b0;
                        busy     <= 1'b1;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        if (cpha) begin
                            tx_sr <= tx_data;
                        end else begin
                            tx_sr <= shift_out(tx_data, lsb_first);
                            mosi  <= first_bit(tx_data, lsb_first);
                        end
                    end
                end
                XFER: begin
                    if (tick) begin
                        sck      <= ~sck;
                        edge_cnt <= edge_next;
                        rx_sr    <= rx_shifted;
                        if (do_drive) begin
                            mosi  <= tx_bit;
                            tx_sr <= tx_shifted;
                        end
                        if (last_edge) begin
                            rx_data <= rx_shifted;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    sck  <= mode[MODE_CPOL];
                    ss_n <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    ss_n <= 1'b1;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Scoreboard bench for spi_master_shifter with a behavioural BRG and SPI slave.
module tb_spi_master_shifter;

    localparam int unsigned DW = 8;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic [DW-1:0] tx_data   = '0;
    logic          cpol      = 1'b0;
    logic          cpha      = 1'b0;
    logic          lsb_first = 1'b0;
    logic          baud      = 1'b0;
    logic          miso;
    logic          brg_clr, sck, mosi, ss_n, busy, done;
    logic [DW-1:0] rx_data;

    spi_master_shifter #(.DataWidth(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tx_data   (tx_data),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .baud      (baud),
        .miso      (miso),
        .brg_clr   (brg_clr),
        .sck       (sck),
        .mosi      (mosi),
        .ss_n      (ss_n),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural BRG: baud toggles every 2^spr clk, held cleared by brg_clr.
    int unsigned spr          = 0;
    int unsigned brg_cnt      = 0;
    int          clr_posedges = 0;
    always @(posedge clk) begin
        if (brg_clr) begin
            clr_posedges++;
            brg_cnt <= 0;
            baud    <= 1'b0;
        end else if (brg_cnt == (1 << spr) - 1) begin
            brg_cnt <= 0;
            baud    <= ~baud;
        end else begin
            brg_cnt <= brg_cnt + 1;
        end
    end

    // Slave: 0 = loop mosi back, 1 = constant 1, 2 = shift out pat in transfer order.
    int            miso_mode = 0;
    logic [DW-1:0] pat       = '0;
    int            bit_idx   = 0;
    logic          cur_pha   = 1'b0;
    logic          cur_lsb   = 1'b0;
    always_comb begin
        miso = mosi;
        if (miso_mode == 1) begin
            miso = 1'b1;
        end else if (miso_mode == 2) begin
            if (bit_idx >= DW) miso = 1'b0;
            else miso = cur_lsb ? pat[bit_idx] : pat[DW-1-bit_idx];
        end
    end

    logic [DW-1:0] sb[$];
    logic          mosi_log[$];
    int   cyc = 0, edges = 0, gmin = 1000, gmax = 0, last_edge_cyc = 0;
    int   ss_rise_cyc = 0, busy_cnt = 0, done_cnt = 0;
    logic sck_prev = 1'b0, ss_prev = 1'b1;

    always @(negedge clk) begin
        logic [DW-1:0] exp;
        int gap;
        cyc++;
        if (rst && !ss_n && (sck !== sck_prev)) begin
            edges++;
            if (edges > 1) begin
                gap = cyc - last_edge_cyc;
                if (gap < gmin) gmin = gap;
                if (gap > gmax) gmax = gap;
            end
            last_edge_cyc = cyc;
            if (((edges % 2) == 1) != cur_pha) begin
                mosi_log.push_back(mosi);
                bit_idx++;
            end
        end
        if (ss_n && !ss_prev) ss_rise_cyc = cyc;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            check_eq("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check_eq("rx_data", rx_data, exp);
            end
        end
        sck_prev = sck;
        ss_prev  = ss_n;
    end

    logic m_pha = 1'b0, m_lsb = 1'b0;

    task automatic prep(input logic pol, input logic pha, input logic lsb,
                        input int unsigned spr_v, input int mmode, input logic [DW-1:0] p);
        @(negedge clk);
        cpol = pol; cpha = pha; lsb_first = lsb;
        spr = spr_v; miso_mode = mmode; pat = p;
        m_pha = pha; m_lsb = lsb;
        @(negedge clk);
    endtask

    // Raises start for one cycle, then scrambles inputs that must not matter.
    task automatic fire(input logic [DW-1:0] tx, input logic [DW-1:0] exp);
        cpha = m_pha; lsb_first = m_lsb; tx_data = tx; start = 1'b1;
        cur_pha = m_pha; cur_lsb = m_lsb;
        edges = 0; bit_idx = 0; busy_cnt = 0; gmin = 1000; gmax = 0;
        mosi_log.delete();
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0; tx_data = ~tx; cpha = ~m_pha; lsb_first = ~m_lsb;
    endtask

    task automatic wait_done(input int base, input int limit);
        int n = 0;
        while (done_cnt == base && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == base) check_eq("done_timeout", done_cnt - base, 32'd1);
    endtask

    task automatic xfer_checks(input int unsigned spr_v);
        check_eq("edges", edges, 2 * DW);
        check_eq("gap_min", gmin, 1 << spr_v);
        check_eq("gap_max", gmax, 1 << spr_v);
        check_eq("busy_span", busy_cnt + 1, (2 * DW << spr_v) + 2);
    endtask

    task automatic ss_checks();
        @(negedge clk);
        #1;
        check_eq("ss_n_after", ss_n, 1'b1);
        check_eq("ss_rise_delay", ss_rise_cyc - last_edge_cyc, 32'd1);
        check_eq("busy_after", busy, 1'b0);
    endtask

    function automatic logic [31:0] pack_log();
        logic [31:0] v = '0;
        foreach (mosi_log[i]) v = {v[30:0], mosi_log[i]};
        return v;
    endfunction

    initial begin
        int base;
        int n;
        #2 rst = 1'b0;
        #1;
        check_eq("rst_sck", sck, 1'b0);
        check_eq("rst_mosi", mosi, 1'b0);
        check_eq("rst_ss_n", ss_n, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_rx", rx_data, 8'h00);
        check_eq("rst_brg_clr", brg_clr, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Mode 0, SPR 0, MSB-first loopback.
        prep(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
        base = done_cnt;
        fire(8'hA5, 8'hA5);
        wait_done(base, 2000);
        xfer_checks(0);
        check_eq("mosi_cnt", mosi_log.size(), DW);
        check_eq("mosi_seq", pack_log(), 32'hA5);
        ss_checks();

        // Mode 3, SPR 2, miso held high.
        prep(1'b1, 1'b1, 1'b0, 2, 1, 8'h00);
        check_eq("sck_idle_hi", sck, 1'b1);
        base = done_cnt;
        fire(8'h3C, 8'hFF);
        wait_done(base, 2000);
        xfer_checks(2);
        ss_checks();
        check_eq("sck_end_hi", sck, 1'b1);

        // Mode 1, LSB-first, slave returns 0x80.
        prep(1'b0, 1'b1, 1'b1, 1, 2, 8'h80);
        base = done_cnt;
        fire(8'h01, 8'h80);
        wait_done(base, 2000);
        xfer_checks(1);
        check_eq("mosi_lsb_seq", pack_log(), 32'h80);
        ss_checks();

        // A second start during XFER must be ignored.
        prep(1'b0, 1'b0, 1'b0, 1, 0, 8'h00);
        base = done_cnt;
        fire(8'h96, 8'h96);
        n = 0;
        while (edges < 5 && n < 200) begin @(negedge clk); #1; n++; end
        check_eq("mid_reach", {31'd0, edges >= 5}, 32'd1);
        tx_data = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(base, 2000);
        xfer_checks(1);
        repeat (40) @(negedge clk);
        check_eq("single_done", done_cnt - base, 32'd1);

        // Asynchronous reset at edge 7 aborts without done.
        prep(1'b0, 1'b0, 1'b0, 1, 0, 8'h00);
        base = done_cnt;
        fire(8'hC3, 8'hC3);
        n = 0;
        while (edges < 7 && n < 200) begin @(negedge clk); #1; n++; end
        check_eq("abort_reach", edges, 32'd7);
        #1 rst = 1'b0;
        #1;
        check_eq("abort_sck", sck, 1'b0);
        check_eq("abort_mosi", mosi, 1'b0);
        check_eq("abort_ss_n", ss_n, 1'b1);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_rx", rx_data, 8'h00);
        check_eq("abort_brg_clr", brg_clr, 1'b1);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("abort_no_done", done_cnt - base, 32'd0);
        prep(1'b0, 1'b0, 1'b0, 1, 0, 8'h00);
        base = done_cnt;
        fire(8'h0F, 8'h0F);
        wait_done(base, 2000);
        xfer_checks(1);
        ss_checks();

        // Back-to-back: restart in the IDLE cycle right after done.
        prep(1'b1, 1'b0, 1'b0, 1, 0, 8'h00);
        base = done_cnt;
        fire(8'h5A, 8'h5A);
        wait_done(base, 2000);
        check_eq("b2b_edges", edges, 2 * DW);
        n = clr_posedges;
        @(negedge clk);
        base = done_cnt;
        fire(8'hC6, 8'hC6);
        check_eq("b2b_clr_clks", clr_posedges - n, 32'd1);
        wait_done(base, 2000);
        xfer_checks(1);
        ss_checks();

        repeat (10) @(negedge clk);
        check_eq("done_total", done_cnt, 32'd7);
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
